// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch unit for the RV32I microcontroller. It owns the program
// counter, issues single-word reads to instruction memory over a valid/ready
// request channel, and captures the returned word. The word is held, already
// split into its decode fields, until the decode stage accepts it. Redirects
// from execute flush any in-flight fetch and restart fetching at the target.
//
// Only one memory request is ever outstanding. A response that belongs to a
// request issued before a redirect is dropped. The pending kill flag marks
// such a response.
//
// Optional feature macro: IFETCH_ILLEGAL_CHK_EN
//   When defined, the instr_illegal port is added. It is registered alongside
//   instr and flags words that are not 32-bit encodings, or whose opcode is
//   outside the supported subset.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   imem_req_valid    request valid (low while reset is asserted)
//   imem_req_ready    memory accepts the request
//   imem_addr         word-aligned fetch address (current pc)
//   imem_rsp_valid    read data valid, one cycle per accepted request
//   imem_rsp_data     returned instruction word
//   redirect_valid    taken branch/jump from execute
//   redirect_pc       redirect target (bits [1:0] ignored)
//   instr_valid       held instruction is valid
//   instr_ready       decode consumes the held instruction
//   instr, instr_pc   held instruction word and its address
//   opcode, rd, funct3, rs1, rs2, funct7   field slices of instr
//   instr_illegal     illegal-encoding flag (IFETCH_ILLEGAL_CHK_EN only)
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  // instruction memory request / response
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  // redirect from execute
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  // held instruction towards decode
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [6:0]  funct7
`ifdef IFETCH_ILLEGAL_CHK_EN
  ,
  output logic        instr_illegal
`endif
);

  // Canonical NOP (addi x0, x0, 0) shown on the instruction outputs after reset.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ  = 2'd0,  // presenting a request at pc
    WAIT = 2'd1,  // request accepted, waiting for the response
    HOLD = 2'd2   // instruction held for decode
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        kill, kill_nxt;
  logic        valid_nxt;
  logic        capture;     // load the response into the instruction register
  logic        req_fire;    // request handshake this cycle
  logic [31:0] redirect_target;

  // The low two target bits are architecturally ignored. Folding them into a
  // named signal documents that they are intentionally dropped.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign redirect_target = {redirect_pc[31:2], 2'b00};

  // Gating with reset keeps the request quiet while reset is held. The state
  // register alone would already read REQ during reset.
  assign imem_req_valid = (state == REQ) && !reset;
  assign imem_addr      = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // ---------------------------------------------------------------------------
  // Next-state and control logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    state_nxt = state;
    pc_nxt    = pc;
    kill_nxt  = kill;
    valid_nxt = instr_valid;
    capture   = 1'b0;

    if (redirect_valid) begin
      // A redirect beats every other event in the same cycle, including a
      // consume in HOLD. The target wins over pc + 4.
      pc_nxt    = redirect_target;
      valid_nxt = 1'b0;
      case (state)
        REQ: begin
          if (req_fire) begin
            // The request just went out at the old pc. Its response must be
            // dropped.
            kill_nxt  = 1'b1;
            state_nxt = WAIT;
          end else begin
            state_nxt = REQ;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            // The outstanding response lands now and is discarded. Nothing is
            // left in flight.
            kill_nxt  = 1'b0;
            state_nxt = REQ;
          end else begin
            // The request is still in flight. This also covers a second
            // redirect while kill is already set.
            kill_nxt  = 1'b1;
            state_nxt = WAIT;
          end
        end
        default: begin
          state_nxt = REQ;
        end
      endcase
    end else begin
      case (state)
        REQ: begin
          // A stray response here has no matching request and is ignored.
          if (req_fire) begin
            state_nxt = WAIT;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            if (kill) begin
              kill_nxt  = 1'b0;
              state_nxt = REQ;
            end else begin
              capture   = 1'b1;
              valid_nxt = 1'b1;
              state_nxt = HOLD;
            end
          end
        end
        HOLD: begin
          if (instr_ready) begin
            valid_nxt = 1'b0;
            pc_nxt    = pc + 32'd4;   // wraps modulo 2^32
            state_nxt = REQ;
          end
        end
        default: begin
          state_nxt = REQ;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State and control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= REQ;
      pc          <= RESET_PC;
      kill        <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples the values from before the edge, whatever the
      // statement order.
      state       <= state_nxt;
      pc          <= pc_nxt;
      kill        <= kill_nxt;
      instr_valid <= valid_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Held instruction register
  // ---------------------------------------------------------------------------
  // NOTE: this payload register is reset even though instr_valid qualifies it.
  // Decode sees a defined NOP on the field outputs straight after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr    <= NOP_INSTR;
      instr_pc <= RESET_PC;
    end else if (capture) begin
      instr    <= imem_rsp_data;
      instr_pc <= pc;
    end
  end

  // Field outputs are plain slices of the held word.
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

`ifdef IFETCH_ILLEGAL_CHK_EN
  // ---------------------------------------------------------------------------
  // Illegal-encoding check, evaluated on the incoming word and registered
  // together with instr so that flag and word always match.
  // ---------------------------------------------------------------------------
  function automatic logic is_illegal(input logic [31:0] word);
    logic opcode_known;
    case (word[6:0])
      7'b0110011,   // OP
      7'b0010011,   // OP-IMM
      7'b0000011,   // LOAD
      7'b0100011,   // STORE
      7'b1100011,   // BRANCH
      7'b0110111,   // LUI
      7'b1101111:   // JAL
        opcode_known = 1'b1;
      default:
        opcode_known = 1'b0;
    endcase
    // Every listed opcode already ends in 2'b11. The explicit length check
    // keeps compressed-style encodings flagged if the list ever grows.
    return (word[1:0] != 2'b11) || !opcode_known;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_illegal <= 1'b0;
    end else if (capture) begin
      instr_illegal <= is_illegal(imem_rsp_data);
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed testbench for instr_fetch (RESET_PC = 32'h100). The bench acts as
// the instruction memory, the decode stage and the execute redirect source.
// Inputs are driven 1 ns after each rising edge. Outputs are checked at that
// same point, well away from the next active edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
`ifdef IFETCH_ILLEGAL_CHK_EN
  logic        instr_illegal;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .opcode         (opcode),
    .rd             (rd),
    .funct3         (funct3),
    .rs1            (rs1),
    .rs2            (rs2),
    .funct7         (funct7)
`ifdef IFETCH_ILLEGAL_CHK_EN
    ,
    .instr_illegal  (instr_illegal)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Hard time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Advance one cycle. Inputs and checks happen 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a request at exp_addr, return data after delay idle cycles, and
  // check that the word is held with the right pc. Expects state REQ and
  // instr_ready low on entry. Leaves the DUT in HOLD.
  task automatic do_fetch(input string name, input logic [31:0] exp_addr,
                          input logic [31:0] data, input int delay);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== exp_addr) begin
      errors++;
      $display("FAIL %s_req: valid=%b addr=%h expected valid=1 addr=%h", name, imem_req_valid, imem_addr, exp_addr);
    end
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    repeat (delay) step();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    step();
    imem_rsp_valid = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instr !== data || instr_pc !== exp_addr) begin
      errors++;
      $display("FAIL %s_hold: valid=%b instr=%h pc=%h expected valid=1 instr=%h pc=%h", name, instr_valid, instr, instr_pc, data, exp_addr);
    end
  endtask

  // Consume the held instruction and check the follow-on request address.
  task automatic do_consume(input string name, input logic [31:0] next_addr);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== next_addr) begin
      errors++;
      $display("FAIL %s_consume: valid=%b req=%b addr=%h expected valid=0 req=1 addr=%h", name, instr_valid, imem_req_valid, imem_addr, next_addr);
    end
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b0;
    step();
    step();
    checks++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: req=%b valid=%b expected 0 0", imem_req_valid, instr_valid);
    end
    checks++;
    if (instr !== 32'h0000_0013 || opcode !== 7'b0010011 || rd !== 5'd0 || funct7 !== 7'd0) begin
      errors++;
      $display("FAIL reset_instr: instr=%h opcode=%b expected 00000013 0010011", instr, opcode);
    end
    checks++;
    if (instr_pc !== 32'h100) begin
      errors++;
      $display("FAIL reset_instr_pc: got %h expected 00000100", instr_pc);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin
      errors++;
      $display("FAIL reset_first_req: req=%b addr=%h expected 1 00000100", imem_req_valid, imem_addr);
    end
  endtask

  // Zero-wait memory with instr_ready held high: one instruction per 3 cycles.
  task automatic test_sequential();
    int t0;
    instr_ready    = 1'b1;
    imem_req_ready = 1'b1;
    step();                                   // REQ -> WAIT
    imem_req_ready = 1'b0;
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL seq_wait_req: got %b expected 0", imem_req_valid);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0050_0093;           // addi x1, x0, 5
    step();                                   // WAIT -> HOLD
    imem_rsp_valid = 1'b0;
    t0 = cyc;
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || rd !== 5'd1 || funct3 !== 3'd0 || opcode !== 7'b0010011) begin
      errors++;
      $display("FAIL seq_first: valid=%b pc=%h rd=%0d funct3=%0d opcode=%b expected 1 00000100 1 0 0010011", instr_valid, instr_pc, rd, funct3, opcode);
    end
    step();                                   // consumed -> REQ
    checks++;
    if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h104) begin
      errors++;
      $display("FAIL seq_next_req: valid=%b req=%b addr=%h expected 0 1 00000104", instr_valid, imem_req_valid, imem_addr);
    end
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0020_81B3;           // add x3, x1, x2
    step();
    imem_rsp_valid = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h104 || funct7 !== 7'd0 || rs2 !== 5'd2 || rs1 !== 5'd1 || rd !== 5'd3) begin
      errors++;
      $display("FAIL seq_second: valid=%b pc=%h funct7=%0d rs2=%0d rs1=%0d rd=%0d expected 1 00000104 0 2 1 3", instr_valid, instr_pc, funct7, rs2, rs1, rd);
    end
    checks++;
    if (cyc - t0 !== 3) begin
      errors++;
      $display("FAIL seq_spacing: got %0d cycles expected 3", cyc - t0);
    end
    step();
    instr_ready = 1'b0;
    checks++;
    if (imem_addr !== 32'h108) begin
      errors++;
      $display("FAIL seq_third_addr: got %h expected 00000108", imem_addr);
    end
  endtask

  task automatic test_decode_stall();
    do_fetch("stall", 32'h108, 32'h00A0_0113, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (instr_valid !== 1'b1 || instr !== 32'h00A0_0113 || instr_pc !== 32'h108 ||
          imem_req_valid !== 1'b0 || imem_addr !== 32'h108) begin
        errors++;
        $display("FAIL stall_cycle%0d: valid=%b instr=%h pc=%h req=%b addr=%h expected 1 00a00113 00000108 0 00000108", i, instr_valid, instr, instr_pc, imem_req_valid, imem_addr);
      end
    end
    do_consume("stall", 32'h10C);
  endtask

  // Redirect while the response for 0x10C is delayed 3 cycles.
  task automatic test_redirect_wait();
    imem_req_ready = 1'b1;
    step();                                   // request accepted, WAIT
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    step();                                   // kill set
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL redir_wait_idle%0d: req=%b valid=%b expected 0 0", i, imem_req_valid, instr_valid);
      end
      if (i == 0) step();
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;           // stale word, must be dropped
    step();
    imem_rsp_valid = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || instr !== 32'h00A0_0113) begin
      errors++;
      $display("FAIL redir_wait_drop: valid=%b instr=%h expected 0 00a00113", instr_valid, instr);
    end
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200) begin
      errors++;
      $display("FAIL redir_wait_addr: req=%b addr=%h expected 1 00000200", imem_req_valid, imem_addr);
    end
    do_fetch("redir_target", 32'h200, 32'h0010_0093, 0);
  endtask

  // Redirect and consume in the same HOLD cycle: the redirect wins.
  task automatic test_redirect_consume();
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h40) begin
      errors++;
      $display("FAIL redir_hold: valid=%b req=%b addr=%h expected 0 1 00000040", instr_valid, imem_req_valid, imem_addr);
    end
  endtask

  // Redirect coinciding with a request handshake, then with a plain response.
  task automatic test_redirect_edges();
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    step();                                   // request at 0x40 killed
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_fire_wait: req=%b expected 0", imem_req_valid);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1234_5678;
    step();
    imem_rsp_valid = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h300) begin
      errors++;
      $display("FAIL redir_fire_restart: valid=%b req=%b addr=%h expected 0 1 00000300", instr_valid, imem_req_valid, imem_addr);
    end
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hCAFE_F00D;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h500;
    step();                                   // response discarded, no kill
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h500 || instr !== 32'h0010_0093) begin
      errors++;
      $display("FAIL redir_rsp: valid=%b req=%b addr=%h instr=%h expected 0 1 00000500 00100093", instr_valid, imem_req_valid, imem_addr, instr);
    end
    // A wrongly set kill would drop this next response.
    do_fetch("redir_rsp_next", 32'h500, 32'h0020_8133, 0);
    do_consume("redir_rsp_next", 32'h504);
  endtask

  // Idle redirect with unaligned target, then pc wrap at the top of memory.
  task automatic test_redirect_wrap();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL redir_idle: req=%b addr=%h expected 1 fffffffc", imem_req_valid, imem_addr);
    end
    do_fetch("wrap", 32'hFFFF_FFFC, 32'h0000_0013, 2);
    do_consume("wrap", 32'h0);
  endtask

  // Reset asserted while a request is outstanding.
  task automatic test_reset_mid_wait();
    do_fetch("pre_reset", 32'h0, 32'h0000_0033, 0);
    do_consume("pre_reset", 32'h4);
    imem_req_ready = 1'b1;
    step();                                   // WAIT
    imem_req_ready = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || opcode !== 7'b0010011 || instr !== 32'h0000_0013 ||
        instr_pc !== 32'h100 || imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: valid=%b opcode=%b instr=%h pc=%h req=%b expected 0 0010011 00000013 00000100 0", instr_valid, opcode, instr, instr_pc, imem_req_valid);
    end
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin
      errors++;
      $display("FAIL reset_restart: req=%b addr=%h expected 1 00000100", imem_req_valid, imem_addr);
    end
    // A stray response with no accepted request must be ignored.
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hFFFF_FFFF;
    step();
    imem_rsp_valid = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || instr !== 32'h0000_0013) begin
      errors++;
      $display("FAIL reset_stray_rsp: valid=%b req=%b instr=%h expected 0 1 00000013", instr_valid, imem_req_valid, instr);
    end
  endtask

  task automatic test_illegal();
`ifdef IFETCH_ILLEGAL_CHK_EN
    do_fetch("illegal", 32'h100, 32'h0000_007F, 0);
    checks++;
    if (instr_illegal !== 1'b1) begin
      errors++;
      $display("FAIL illegal_7f: got %b expected 1", instr_illegal);
    end
    do_consume("illegal", 32'h104);
    do_fetch("legal", 32'h104, 32'h0000_0013, 0);
    checks++;
    if (instr_illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_13: got %b expected 0", instr_illegal);
    end
    do_consume("legal", 32'h108);
`endif
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_decode_stall();
    test_redirect_wait();
    test_redirect_consume();
    test_redirect_edges();
    test_redirect_wrap();
    test_reset_mid_wait();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the RV32I microcontroller: it supplies the instruction stream to the decoder (`cu`). It keeps the program counter, issues word reads to instruction memory over a valid/ready request and response interface, and holds each fetched instruction, already split into opcode/funct3/funct7/register fields, until the decode stage accepts it. Branch and jump redirects from execute flush any in-flight fetch and restart at the target.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset. Bits [1:0] must be 0.
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_ready`  in  1  memory accepts request
- `imem_addr`  out  32  word address of request (bits [1:0] = 0)
- `imem_rsp_valid`  in  1  read data valid, one cycle per accepted request
- `imem_rsp_data`  in  32  instruction word
- `redirect_valid`  in  1  taken branch or jump
- `redirect_pc`  in  32  target; bits [1:0] are ignored and forced to 0
- `instr_valid`  out  1  held instruction is valid
- `instr_ready`  in  1  decode consumes the held instruction
- `instr`  out  32  raw instruction
- `instr_pc`  out  32  PC of `instr`
- `opcode`  out  7  `instr[6:0]`
- `rd`  out  5  `instr[11:7]`
- `funct3`  out  3  `instr[14:12]`
- `rs1`  out  5  `instr[19:15]`
- `rs2`  out  5  `instr[24:20]`
- `funct7`  out  7  `instr[31:25]`
- `instr_illegal`  out  1  present only when `IFETCH_ILLEGAL_CHK_EN` is defined (see Configuration)

## Operation
- **Reset values:**
  - State: REQ.
  - `pc`: `RESET_PC`.
  - `kill`: 0.
  - `instr_valid`: 0.
  - `instr`: 32'h0000_0013 (NOP), so `opcode` = 7'b0010011 and all other fields are 0.
  - `instr_pc`: `RESET_PC`.
  - `imem_req_valid`: 0 while `reset` is high.
- **Outputs:** `imem_req_valid` = (state == REQ) && !reset. `imem_addr` = `pc`. All field outputs are slices of the `instr` register.
- **At most one outstanding memory request.**
- **States:**
  - REQ: on `imem_req_valid && imem_req_ready`, go to WAIT.
  - WAIT: on `imem_rsp_valid`:
    - If `kill` is set: discard the data, clear `kill`, go to REQ.
    - Otherwise: `instr` <= `imem_rsp_data`, `instr_pc` <= `pc`, `instr_valid` <= 1, go to HOLD.
  - HOLD: on `instr_ready`: `instr_valid` <= 0, `pc` <= `pc` + 4 (wraps modulo 2^32), go to REQ.
- **Redirect** has highest priority and applies in any state:
  - `pc` <= {`redirect_pc[31:2]`, 2'b00}.
  - `instr_valid` <= 0.
  - If a request is outstanding (state WAIT without a response this cycle, or REQ with handshake this cycle): `kill` <= 1, next state WAIT.
  - Otherwise: next state REQ.
- **Simultaneous events:**
  - Redirect with `instr_ready` in HOLD: the redirect wins. `pc` becomes the target, not `pc` + 4.
  - Redirect with `imem_rsp_valid` in WAIT: the response is discarded, `kill` stays 0, go to REQ.
  - A second redirect while `kill` is set: update `pc`, keep `kill` set.
- **Reset mid-operation:** asynchronous return to the reset values. A response arriving after reset deassertion with no accepted request is ignored (REQ state ignores `imem_rsp_valid`).
- **Stability:** `instr` and `instr_pc` are stable while `instr_valid` && !`instr_ready`.

## Timing
- Best-case issue: request accepted in cycle N, response in cycle N+1, `instr_valid` high in cycle N+2.
- Next request is issued in the cycle after `instr_ready` is sampled.
- Throughput with zero-wait memory and continuous `instr_ready`: one instruction per 3 cycles.
- Redirect latency: the new `imem_addr` appears the cycle after `redirect_valid` when no request is outstanding. Otherwise it appears the cycle after the killed response returns.
- `instr_valid` falls in the cycle after the redirect or consume event.

## Configuration
- `IFETCH_ILLEGAL_CHK_EN` defined:
  - The `instr_illegal` port exists. It is registered with `instr` and resets to 0.
  - It is set when `instr[1:0]` != 2'b11.
  - It is also set when `opcode` is not one of 0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 1101111.
- `IFETCH_ILLEGAL_CHK_EN` undefined: no port and no logic. The instruction is passed through unchecked.

## Test plan
- **Reset:** assert `reset` mid-WAIT with `RESET_PC` = 32'h100 -> `instr_valid` = 0 and `opcode` = 7'b0010011 immediately. After release, first request at `imem_addr` = 32'h100.
- **Sequential fetch:** zero-wait memory returns 32'h00500093 at 0x100 and 32'h002081B3 at 0x104, `instr_ready` = 1 -> `instr_pc` 0x100 then 0x104, 3 cycles apart; `rd` = 1 and `funct3` = 0, then `funct7` = 0 and `rs2` = 2.
- **Decode stall:** hold `instr_ready` = 0 for 5 cycles -> `instr` stable, no new `imem_req_valid`, `pc` unchanged.
- **Redirect during WAIT:** `redirect_pc` = 32'h203 while the response is delayed 3 cycles -> that response is dropped, next `imem_addr` = 32'h200, and `instr_valid` never shows the stale word.
- **Simultaneous redirect and consume in HOLD:** `redirect_pc` = 32'h40 with `instr_ready` = 1 -> next request address is 32'h40, not `pc` + 4.
- **Illegal check** (`IFETCH_ILLEGAL_CHK_EN` defined): fetch 32'h0000007F -> `instr_illegal` = 1. Fetch 32'h00000013 -> `instr_illegal` = 0.
